adv7513_i2c_arbiter: RTL
========================

Name: adv7513_i2c_arbiter

Overview:
Shares the single ADV7513 i2c_master instance between two requesters: port 0 (init/config sequencer, writes) and port 1 (debug register reader, reads/writes). Grants round-robin, issues one single-byte transaction per grant, waits for completion, retries on bus error or timeout, and returns read data and status to the granted requester. Sits between the requesters and i2c_master; chip address is fixed per build.

Parameters:
CHIP_ADDR, 7'h72, 7-bit I2C address driven on m_chip_addr for every transaction.
TIMEOUT, 100000, max clk cycles spent in S_START plus S_BUSY for one attempt before abort; width 17 bits internal.
MAX_RETRY, 2, re-attempts after a failed attempt (total attempts = MAX_RETRY+1); 0..7.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  2  request per port, level; held until ack
we  in  2  per port: 1 = write, 0 = read; sampled at grant
reg_addr0  in  8  port 0 register address
wdata0  in  8  port 0 write data
reg_addr1  in  8  port 1 register address
wdata1  in  8  port 1 write data
ack  out  2  one-cycle completion pulse per port
err  out  1  valid with ack: 1 = all attempts failed
rdata  out  8  read data, valid with ack on read
m_chip_addr  out  7  to i2c_master chip_addr
m_reg_addr  out  8  to i2c_master reg_addr
m_data_in  out  8  to i2c_master data_in
m_write_en  out  1  one-cycle write strobe
m_read_en  out  1  one-cycle read strobe
m_busy  in  1  from i2c_master busy
m_status  in  3  from i2c_master status; nonzero at busy fall = error
m_data_out  in  8  from i2c_master data_out
grant  out  2  one-hot current owner, 0 when idle

Behaviour:
- Reset (clk edge with reset=1): state S_IDLE, ack=0, err=0, rdata=0, m_write_en=0, m_read_en=0, m_reg_addr=0, m_data_in=0, grant=0, last=1 (port 0 wins first tie), retry counter 0, timeout counter 0. m_chip_addr is constant CHIP_ADDR. Reset mid-transaction aborts immediately; no ack is issued for the aborted request.
- S_IDLE: if req!=0 and m_busy=0: pick port; if both set, pick port != last; else the single requester. Latch we, reg_addr, wdata of winner into m_reg_addr/m_data_in/op; grant<=onehot, last<=winner, retry<=0 -> S_ISSUE. If m_busy=1, stay.
- S_ISSUE (1 cycle): assert m_write_en (op=1) or m_read_en (op=0) for exactly this cycle; clear timeout counter -> S_START.
- S_START: wait for m_busy=1 -> S_BUSY. Timeout counter increments each cycle.
- S_BUSY: on m_busy=0: success if m_status==0, else fail. Timeout counter continues.
- Timeout: counter reaching TIMEOUT in S_START or S_BUSY = fail; if m_busy still 1, go to S_DRAIN (wait m_busy=0, no counter) before retry/response.
- Fail with retry<MAX_RETRY: retry++ -> S_ISSUE (same operands). Fail with retry==MAX_RETRY: -> S_RESP with err=1.
- Success -> S_RESP with err=0; on read rdata<=m_data_out captured the cycle m_busy falls; on write rdata unchanged.
- S_RESP (1 cycle): ack[owner]=1, err valid; grant<=0 -> S_IDLE. Next arbitration no earlier than the cycle after ack, so a requester dropping req on ack is never re-granted.
- Latency, fault-free, m_busy rising 1 cycle after strobe: grant to strobe 1 cycle; ack 1 cycle after the m_busy fall is seen.
- req deasserted while granted: ignored; transaction completes and ack pulses anyway.
- Operand changes after grant are ignored (latched).
- Outputs m_reg_addr/m_data_in stable from S_ISSUE through completion.

Test Plan:
- Single write port 0, reg 0x41 data 0x10, BFM busy 20 cycles status 0 -> one m_write_en pulse, m_reg_addr=0x41, m_data_in=0x10, ack=2'b01, err=0.
- Read port 1 reg 0x00, BFM returns 0x13 -> m_read_en pulse, ack=2'b10, rdata=0x13, err=0.
- Both req asserted continuously from reset -> grants alternate 0,1,0,1 over 4 transactions; port 0 first.
- BFM status=3 on first two attempts, 0 on third, MAX_RETRY=2 -> 3 strobes, single ack, err=0; status always 3 -> 3 strobes, ack with err=1.
- BFM never raises busy, TIMEOUT=50 -> strobe every ~51 cycles, 3 attempts, then ack err=1; busy stuck high -> S_DRAIN holds until busy falls, no new strobe while busy.
- reset=1 during S_BUSY -> next cycle all outputs at reset values, no ack; new request afterwards completes normally.

Source files
------------

// File: rtl/adv7513_i2c_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared ADV7513 i2c_master.
// slave = arbiter view, master = requesters plus i2c_master view.
interface adv7513_i2c_arbiter_if;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] reg_addr0;
    logic [7:0] wdata0;
    logic [7:0] reg_addr1;
    logic [7:0] wdata1;
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    logic [6:0] m_chip_addr;
    logic [7:0] m_reg_addr;
    logic [7:0] m_data_in;
    logic       m_write_en;
    logic       m_read_en;
    logic       m_busy;
    logic [2:0] m_status;
    logic [7:0] m_data_out;
    logic [1:0] grant;

    modport slave (
        input  req, we, reg_addr0, wdata0, reg_addr1, wdata1, m_busy, m_status, m_data_out,
        output ack, err, rdata, m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
        grant
    );

    modport master (
        output req, we, reg_addr0, wdata0, reg_addr1, wdata1, m_busy, m_status, m_data_out,
        input  ack, err, rdata, m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
        grant
    );
endinterface

// File: rtl/adv7513_i2c_arbiter.sv
// Round-robin arbiter sharing one ADV7513 i2c_master between a config sequencer (port 0)
// and a debug register reader (port 1), with per-attempt timeout and bounded retry.
module adv7513_i2c_arbiter #(
    parameter logic [6:0]  CHIP_ADDR = 7'h72,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic                  clk,
    input logic                  reset,
    adv7513_i2c_arbiter_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StStart, StBusy, StDrain, StResp} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        r_op;
    logic        r_last;
    logic        r_err;
    logic [1:0]  r_grant;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_data_in;
    logic [7:0]  r_rdata;
    logic [2:0]  r_retry;
    logic [16:0] r_tmo;

    logic w_win;
    logic w_tmo;
    logic w_retry;
    logic w_ok;
    logic w_fail;

    // On a tie the port that did not win last time gets the bus.
    assign w_win   = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_tmo   = (r_tmo == 17'(TIMEOUT - 1));
    assign w_retry = (r_retry < 3'(MAX_RETRY));

    always_comb begin
        w_state_d = r_state;
        w_ok      = 1'b0;
        w_fail    = 1'b0;
        case (r_state)
            StIdle:  if ((bus.req != 2'b00) && !bus.m_busy) w_state_d = StIssue;
            StIssue: w_state_d = StStart;
            StStart: begin
                if (bus.m_busy) w_state_d = StBusy;
                else if (w_tmo) w_fail = 1'b1;
            end
            StBusy: begin
                if (!bus.m_busy) begin
                    w_ok   = (bus.m_status == 3'd0);
                    w_fail = (bus.m_status != 3'd0);
                end else if (w_tmo) begin
                    w_state_d = StDrain;
                end
            end
            // A timed-out attempt may not be reissued until the master lets go of the bus.
            StDrain: if (!bus.m_busy) w_fail = 1'b1;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_ok) begin
            w_state_d = StResp;
        end else if (w_fail) begin
            w_state_d = w_retry ? StIssue : StResp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_op       <= 1'b0;
            r_last     <= 1'b1;
            r_err      <= 1'b0;
            r_grant    <= 2'b00;
            r_reg_addr <= 8'h00;
            r_data_in  <= 8'h00;
            r_rdata    <= 8'h00;
            r_retry    <= 3'd0;
            r_tmo      <= 17'd0;
        end else begin
            r_state <= w_state_d;
            r_err   <= (w_state_d == StResp) && w_fail;
            if ((r_state == StIdle) && (w_state_d == StIssue)) begin
                r_op       <= bus.we[w_win];
                r_reg_addr <= w_win ? bus.reg_addr1 : bus.reg_addr0;
                r_data_in  <= w_win ? bus.wdata1 : bus.wdata0;
                r_grant    <= w_win ? 2'b10 : 2'b01;
                r_last     <= w_win;
                r_retry    <= 3'd0;
            end
            if (r_state == StIssue) begin
                r_tmo <= 17'd0;
            end else if ((r_state == StStart) || (r_state == StBusy)) begin
                r_tmo <= r_tmo + 17'd1;
            end
            if (w_fail && w_retry) r_retry <= r_retry + 3'd1;
            if (w_ok && !r_op) r_rdata <= bus.m_data_out;
            if (r_state == StResp) r_grant <= 2'b00;
        end
    end

    assign bus.m_chip_addr = CHIP_ADDR;
    assign bus.m_reg_addr  = r_reg_addr;
    assign bus.m_data_in   = r_data_in;
    assign bus.m_write_en  = (r_state == StIssue) && r_op;
    assign bus.m_read_en   = (r_state == StIssue) && !r_op;
    assign bus.ack         = (r_state == StResp) ? r_grant : 2'b00;
    assign bus.err         = r_err;
    assign bus.rdata       = r_rdata;
    assign bus.grant       = r_grant;

endmodule
